// File: rtl/idu_pkg.sv
// idu_pkg: shared definitions for the RV32I decode stage.
//   - opcode constants for every recognised instruction class
//   - bit positions inside the one-hot instruction-type vector {J,U,B,S,I,R}
//   - id_pkt_t, the decoded packet held in the output register
package idu_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_J     = 7'b1101111;

  localparam int unsigned T_R = 0;
  localparam int unsigned T_I = 1;
  localparam int unsigned T_S = 2;
  localparam int unsigned T_B = 3;
  localparam int unsigned T_U = 4;
  localparam int unsigned T_J = 5;

  // Packet PC field is sized for the widest supported PC; PC_W <= 32.
  localparam int unsigned PKT_PC_W = 32;

  typedef struct packed {
    logic [PKT_PC_W-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [5:0]          instr_type;
    logic [31:0]         imm;
    logic                illegal;
  } id_pkt_t;

endpackage

// File: rtl/idu_pipe_if.sv
// idu_pipe_if: fetch-side and execute-side handshakes of the decode stage.
//   Fetch  : if_valid_i, if_ready_o, if_instr_i[31:0], if_pc_i[PC_W-1:0]
//   Execute: id_valid_o, id_ready_i, id_pc_o, rs1_o, rs2_o, rd_o, op_o,
//            funct3_o, funct7_o, instr_type_o, instr_imm_o, illegal_o
//   modport slave  : the decode stage
//   modport master : the surrounding pipeline (fetch + execute)
interface idu_pipe_if #(
  parameter int unsigned PC_W = 32
);
  logic            if_valid_i;
  logic            if_ready_o;
  logic [31:0]     if_instr_i;
  logic [PC_W-1:0] if_pc_i;

  logic            id_valid_o;
  logic            id_ready_i;
  logic [PC_W-1:0] id_pc_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [6:0]      op_o;
  logic [2:0]      funct3_o;
  logic [6:0]      funct7_o;
  logic [5:0]      instr_type_o;
  logic [31:0]     instr_imm_o;
  logic            illegal_o;

  modport slave (
    input  if_valid_i, if_instr_i, if_pc_i, id_ready_i,
    output if_ready_o, id_valid_o, id_pc_o, rs1_o, rs2_o, rd_o, op_o,
           funct3_o, funct7_o, instr_type_o, instr_imm_o, illegal_o
  );

  modport master (
    output if_valid_i, if_instr_i, if_pc_i, id_ready_i,
    input  if_ready_o, id_valid_o, id_pc_o, rs1_o, rs2_o, rd_o, op_o,
           funct3_o, funct7_o, instr_type_o, instr_imm_o, illegal_o
  );
endinterface

// File: rtl/idu_dec.sv
// idu_dec: combinational RV32I field/immediate decoder.
//   instr_i : raw 32-bit instruction
//   pkt_o   : decoded fields (pc field left zero; the caller fills it)
// Optional macro IDU_ILLEGAL_CHK_EN enables the illegal-instruction check;
// without it pkt_o.illegal is constant 0.
module idu_dec
  import idu_pkg::*;
(
  input  logic [31:0] instr_i,
  output id_pkt_t     pkt_o
);

  always_comb begin
    pkt_o        = '0;
    pkt_o.rs1    = instr_i[19:15];
    pkt_o.rs2    = instr_i[24:20];
    pkt_o.rd     = instr_i[11:7];
    pkt_o.op     = instr_i[6:0];
    pkt_o.funct3 = instr_i[14:12];
    pkt_o.funct7 = instr_i[31:25];

    case (instr_i[6:0])
      OPC_R: pkt_o.instr_type[T_R] = 1'b1;
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        pkt_o.instr_type[T_I] = 1'b1;
        pkt_o.imm = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_S: begin
        pkt_o.instr_type[T_S] = 1'b1;
        pkt_o.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_B: begin
        pkt_o.instr_type[T_B] = 1'b1;
        pkt_o.imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        pkt_o.instr_type[T_U] = 1'b1;
        pkt_o.imm = {instr_i[31:12], 12'h000};
      end
      OPC_J: begin
        pkt_o.instr_type[T_J] = 1'b1;
        pkt_o.imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
      end
      default: ;
    endcase

`ifdef IDU_ILLEGAL_CHK_EN
    // Unknown opcodes (FENCE/SYSTEM included) leave instr_type all-zero.
    if (instr_i[1:0] != 2'b11 || pkt_o.instr_type == '0)
      pkt_o.illegal = 1'b1;
    if (pkt_o.instr_type[T_R]) begin
      if (instr_i[31:25] != 7'b0000000 && instr_i[31:25] != 7'b0100000)
        pkt_o.illegal = 1'b1;
      if (instr_i[31:25] == 7'b0100000 &&
          instr_i[14:12] != 3'b000 && instr_i[14:12] != 3'b101)
        pkt_o.illegal = 1'b1;
    end
    if (pkt_o.instr_type[T_B] &&
        (instr_i[14:12] == 3'b010 || instr_i[14:12] == 3'b011))
      pkt_o.illegal = 1'b1;
`endif
  end

endmodule

// File: rtl/idu_pipe.sv
// idu_pipe: pipelined RV32I decode stage.
//   clk_i, rst_ni (async active-low), flush_i (synchronous flush)
//   bus     : idu_pipe_if.slave -- fetch handshake in, decode packet out
//   count_o : instruction buffer occupancy
// A DEPTH-entry instruction buffer feeds idu_dec on its head entry; the
// decoded packet is registered into the output stage, giving DEPTH+1
// instructions in flight. Optional macro IDU_ILLEGAL_CHK_EN (in idu_dec)
// drives illegal_o.
module idu_pipe
  import idu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
)(
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  idu_pipe_if.slave                  bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             out_valid_q;
  id_pkt_t          out_pkt_q;
  id_pkt_t          dec_pkt;
  id_pkt_t          head_pkt;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy, so a pop never raises it
  // in the same cycle and id_ready_i has no combinational path to it.
  assign bus.if_ready_o = rst_ni & (count_q < CNT_W'(DEPTH));
  assign push = bus.if_valid_i & bus.if_ready_o;
  assign pop  = (count_q != '0) & (~out_valid_q | bus.id_ready_i);

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      instr_mem[wr_ptr_q] <= bus.if_instr_i;
      pc_mem[wr_ptr_q]    <= bus.if_pc_i;
    end
  end

  idu_dec u_dec (
    .instr_i (instr_mem[rd_ptr_q]),
    .pkt_o   (dec_pkt)
  );

  always_comb begin
    head_pkt    = dec_pkt;
    head_pkt.pc = PKT_PC_W'(pc_mem[rd_ptr_q]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
      if (pop) begin
        out_valid_q <= 1'b1;
        out_pkt_q   <= head_pkt;
      end else if (bus.id_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign count_o          = count_q;
  assign bus.id_valid_o   = out_valid_q;
  assign bus.id_pc_o      = out_pkt_q.pc[PC_W-1:0];
  assign bus.rs1_o        = out_pkt_q.rs1;
  assign bus.rs2_o        = out_pkt_q.rs2;
  assign bus.rd_o         = out_pkt_q.rd;
  assign bus.op_o         = out_pkt_q.op;
  assign bus.funct3_o     = out_pkt_q.funct3;
  assign bus.funct7_o     = out_pkt_q.funct7;
  assign bus.instr_type_o = out_pkt_q.instr_type;
  assign bus.instr_imm_o  = out_pkt_q.imm;
  assign bus.illegal_o    = out_pkt_q.illegal;

endmodule
